// File: rtl/inst_mem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter.
// Holds the bus widths, the idle/enable constants, the default loader streak limit
// and the FSM state and grant encodings used by the arbiter and its priority sub-block.
package inst_mem_arbiter_pkg;

  localparam int unsigned InstAddrW = 32;
  localparam int unsigned InstW     = 32;

  localparam logic [InstW-1:0] ZeroWord    = '0;
  localparam logic             ChipEnable  = 1'b1;
  localparam logic             ChipDisable = 1'b0;

  localparam int unsigned LdMaxStreakDefault = 3;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StFetchRsp = 2'd1,
    StLoadRsp  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GntNone  = 2'd0,
    GntFetch = 2'd1,
    GntLoad  = 2'd2
  } grant_e;

endpackage

// File: rtl/inst_mem_arbiter_prio.sv
// Priority decision between the fetch port and the loader/debug port.
// Ports:
//   fetch_req  - fetch requester active
//   ld_req     - loader requester active
//   ld_streak  - consecutive loader grants while a fetch was waiting
//   grant      - GntNone / GntFetch / GntLoad
// The loader normally wins; once it has won LD_MAX_STREAK times in a row over a
// waiting fetch, the fetch is given the next slot.
module inst_arb_prio
  import inst_mem_arbiter_pkg::*;
#(
  parameter int unsigned LD_MAX_STREAK = LdMaxStreakDefault,
  parameter int unsigned StreakW       = 2
) (
  input  logic               fetch_req,
  input  logic               ld_req,
  input  logic [StreakW-1:0] ld_streak,
  output logic [1:0]         grant
);

  logic streak_full;
  assign streak_full = (ld_streak == StreakW'(LD_MAX_STREAK));

  always_comb begin
    grant = GntNone;
    if (ld_req && !(fetch_req && streak_full)) begin
      grant = GntLoad;
    end else if (fetch_req) begin
      grant = GntFetch;
    end
  end

endmodule

// File: rtl/inst_mem_arbiter.sv
// Two-port arbiter in front of a single-ported instruction memory.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   fetch_req_i/fetch_addr_i          - pipeline fetch request
//   fetch_rdata_o/fetch_valid_o       - fetch response (one-cycle strobe)
//   fetch_misalign_o                  - fetch address not word aligned, valid with strobe
//   stall_req_o                       - fetch outstanding and not yet answered
//   ld_req_i/ld_we_i/ld_addr_i/ld_wdata_i - loader/debug access
//   ld_ack_o/ld_rdata_o               - loader completion strobe and read data
//   mem_ce_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i - external memory port
// Every access takes two cycles: issue in StIdle, response in the *Rsp state.
module inst_mem_arbiter
  import inst_mem_arbiter_pkg::*;
#(
  parameter int unsigned LD_MAX_STREAK = LdMaxStreakDefault
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_req_i,
  input  logic [InstAddrW-1:0] fetch_addr_i,
  output logic [InstW-1:0]     fetch_rdata_o,
  output logic                 fetch_valid_o,
  output logic                 fetch_misalign_o,
  output logic                 stall_req_o,
  input  logic                 ld_req_i,
  input  logic                 ld_we_i,
  input  logic [InstAddrW-1:0] ld_addr_i,
  input  logic [InstW-1:0]     ld_wdata_i,
  output logic                 ld_ack_o,
  output logic [InstW-1:0]     ld_rdata_o,
  output logic                 mem_ce_o,
  output logic                 mem_we_o,
  output logic [InstAddrW-1:0] mem_addr_o,
  output logic [InstW-1:0]     mem_wdata_o,
  input  logic [InstW-1:0]     mem_rdata_i
);

  localparam int unsigned StreakW = (LD_MAX_STREAK < 1) ? 1 : $clog2(LD_MAX_STREAK + 1);

  arb_state_e         state_q;
  logic               ld_we_q;
  logic               misalign_q;
  logic [StreakW-1:0] ld_streak_q;
  logic [1:0]         grant;
  logic               fetch_misaligned;
  logic               unused_ld_addr;

  assign fetch_misaligned = (fetch_addr_i[1:0] != 2'b00);
  // Loader accesses are always word aligned; the low address bits are dropped.
  assign unused_ld_addr   = ^ld_addr_i[1:0];

  inst_arb_prio #(
    .LD_MAX_STREAK (LD_MAX_STREAK),
    .StreakW       (StreakW)
  ) u_prio (
    .fetch_req (fetch_req_i),
    .ld_req    (ld_req_i),
    .ld_streak (ld_streak_q),
    .grant     (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ld_we_q     <= 1'b0;
      misalign_q  <= 1'b0;
      ld_streak_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant == GntFetch) begin
            state_q    <= StFetchRsp;
            misalign_q <= fetch_misaligned;
          end else if (grant == GntLoad) begin
            state_q <= StLoadRsp;
            ld_we_q <= ld_we_i;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Streak only counts loader wins over a waiting fetch.
      if (!fetch_req_i || (state_q == StIdle && grant == GntFetch)) begin
        ld_streak_q <= '0;
      end else if (state_q == StIdle && grant == GntLoad &&
                   ld_streak_q != StreakW'(LD_MAX_STREAK)) begin
        ld_streak_q <= ld_streak_q + StreakW'(1);
      end
    end
  end

  always_comb begin
    mem_ce_o         = ChipDisable;
    mem_we_o         = 1'b0;
    mem_addr_o       = ZeroWord;
    mem_wdata_o      = ZeroWord;
    fetch_rdata_o    = ZeroWord;
    fetch_valid_o    = 1'b0;
    fetch_misalign_o = 1'b0;
    ld_ack_o         = 1'b0;
    ld_rdata_o       = ZeroWord;
    // Reset blanks the outputs immediately, so an aborted response never strobes.
    if (!rst) begin
      case (state_q)
        StIdle: begin
          if (grant == GntFetch && !fetch_misaligned) begin
            mem_ce_o   = ChipEnable;
            mem_addr_o = fetch_addr_i;
          end else if (grant == GntLoad) begin
            mem_ce_o    = ChipEnable;
            mem_we_o    = ld_we_i;
            mem_addr_o  = {ld_addr_i[InstAddrW-1:2], 2'b00};
            mem_wdata_o = ld_wdata_i;
          end
        end
        StFetchRsp: begin
          fetch_valid_o    = 1'b1;
          fetch_misalign_o = misalign_q;
          fetch_rdata_o    = misalign_q ? ZeroWord : mem_rdata_i;
        end
        StLoadRsp: begin
          ld_ack_o   = 1'b1;
          ld_rdata_o = ld_we_q ? ZeroWord : mem_rdata_i;
        end
        default: ;
      endcase
    end
    stall_req_o = !rst && fetch_req_i && !fetch_valid_o;
  end

endmodule

// File: tb/tb_inst_mem_arbiter.sv
module tb_inst_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req_i;
  logic [31:0] fetch_addr_i;
  logic [31:0] fetch_rdata_o;
  logic        fetch_valid_o;
  logic        fetch_misalign_o;
  logic        stall_req_o;
  logic        ld_req_i;
  logic        ld_we_i;
  logic [31:0] ld_addr_i;
  logic [31:0] ld_wdata_i;
  logic        ld_ack_o;
  logic [31:0] ld_rdata_o;
  logic        mem_ce_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_mem_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_req_i      (fetch_req_i),
    .fetch_addr_i     (fetch_addr_i),
    .fetch_rdata_o    (fetch_rdata_o),
    .fetch_valid_o    (fetch_valid_o),
    .fetch_misalign_o (fetch_misalign_o),
    .stall_req_o      (stall_req_o),
    .ld_req_i         (ld_req_i),
    .ld_we_i          (ld_we_i),
    .ld_addr_i        (ld_addr_i),
    .ld_wdata_i       (ld_wdata_i),
    .ld_ack_o         (ld_ack_o),
    .ld_rdata_o       (ld_rdata_o),
    .mem_ce_o         (mem_ce_o),
    .mem_we_o         (mem_we_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_rdata_i      (mem_rdata_i)
  );

  // Memory model: 16 words, read data one cycle after the enable cycle.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[4]      <= 32'h3401_0020;
      mem_rdata_i <= 32'h0;
    end else if (mem_ce_o) begin
      if (mem_we_o) mem[mem_addr_o[5:2]] <= mem_wdata_o;
      else          mem_rdata_i <= mem[mem_addr_o[5:2]];
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fetch_req_i = 0; fetch_addr_i = 0;
    ld_req_i = 0; ld_we_i = 0; ld_addr_i = 0; ld_wdata_i = 0;
    repeat (2) next_cycle();
    @(negedge clk);
    checks++;
    if (mem_ce_o !== 1'b0) begin
      errors++; $display("FAIL reset_mem_ce got %b want 0", mem_ce_o);
    end
    checks++;
    if ({fetch_valid_o, ld_ack_o, stall_req_o, mem_we_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b want 0000",
               {fetch_valid_o, ld_ack_o, stall_req_o, mem_we_o});
    end
    checks++;
    if ({mem_addr_o, mem_wdata_o, fetch_rdata_o, ld_rdata_o} !== 128'h0) begin
      errors++; $display("FAIL reset_data got %h/%h want 0", mem_addr_o, ld_rdata_o);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_ce_o !== 1'b0) begin
      errors++; $display("FAIL idle_mem_ce got %b want 0", mem_ce_o);
    end
  endtask

  task automatic test_fetch();
    next_cycle();
    fetch_req_i = 1; fetch_addr_i = 32'h0000_0010;
    @(negedge clk);
    checks++;
    if ({mem_ce_o, mem_we_o, mem_addr_o} !== {2'b10, 32'h10}) begin
      errors++; $display("FAIL fetch_issue got ce=%b we=%b addr=%h want 1 0 10",
                         mem_ce_o, mem_we_o, mem_addr_o);
    end
    checks++;
    if ({stall_req_o, fetch_valid_o} !== 2'b10) begin
      errors++; $display("FAIL fetch_stall0 got %b%b want 10", stall_req_o, fetch_valid_o);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({fetch_valid_o, fetch_misalign_o, fetch_rdata_o} !== {2'b10, 32'h3401_0020}) begin
      errors++; $display("FAIL fetch_rsp got v=%b m=%b d=%h want 1 0 34010020",
                         fetch_valid_o, fetch_misalign_o, fetch_rdata_o);
    end
    checks++;
    if ({stall_req_o, mem_ce_o} !== 2'b00) begin
      errors++; $display("FAIL fetch_stall1 got %b%b want 00", stall_req_o, mem_ce_o);
    end
    next_cycle();
    fetch_req_i = 0;
  endtask

  task automatic test_ld_write_read();
    ld_req_i = 1; ld_we_i = 1; ld_addr_i = 32'h0000_0007; ld_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {2'b11, 32'h4, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL ld_write_issue got ce=%b we=%b addr=%h wd=%h want 1 1 4 deadbeef",
                         mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o);
    end
    checks++;
    if (ld_ack_o !== 1'b0) begin
      errors++; $display("FAIL ld_write_early_ack got %b want 0", ld_ack_o);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({ld_ack_o, ld_rdata_o, mem_ce_o} !== {1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL ld_write_ack got ack=%b d=%h ce=%b want 1 0 0",
                         ld_ack_o, ld_rdata_o, mem_ce_o);
    end
    next_cycle();
    ld_we_i = 0; ld_addr_i = 32'h0000_0004; ld_wdata_i = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if ({mem_ce_o, mem_we_o, mem_addr_o} !== {2'b10, 32'h4}) begin
      errors++; $display("FAIL ld_read_issue got ce=%b we=%b addr=%h want 1 0 4",
                         mem_ce_o, mem_we_o, mem_addr_o);
    end
    next_cycle();
    ld_req_i = 0;
    @(negedge clk);
    checks++;
    if ({ld_ack_o, ld_rdata_o} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL ld_read_ack got ack=%b d=%h want 1 deadbeef", ld_ack_o, ld_rdata_o);
    end
    next_cycle();
  endtask

  task automatic test_misalign();
    fetch_req_i = 1; fetch_addr_i = 32'h0000_0002;
    @(negedge clk);
    checks++;
    if ({mem_ce_o, mem_addr_o} !== 33'h0) begin
      errors++; $display("FAIL misalign_issue got ce=%b addr=%h want 0 0", mem_ce_o, mem_addr_o);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({fetch_valid_o, fetch_misalign_o, fetch_rdata_o} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL misalign_rsp got v=%b m=%b d=%h want 1 1 0",
                         fetch_valid_o, fetch_misalign_o, fetch_rdata_o);
    end
    next_cycle();
    fetch_req_i = 0;
  endtask

  task automatic test_arbitration();
    logic [32:0] exp_issue;
    logic [1:0]  exp_rsp;
    next_cycle();
    fetch_req_i = 1; fetch_addr_i = 32'h0000_0010;
    ld_req_i = 1; ld_we_i = 0; ld_addr_i = 32'h0000_0000;
    for (int c = 0; c < 16; c++) begin
      // Even cycles issue: three loader grants then one fetch grant.
      if (c % 2 == 0) exp_issue = {1'b1, (((c / 2) % 4) == 3) ? 32'h10 : 32'h0};
      else            exp_issue = 33'h0;
      exp_rsp[1] = (c % 8 == 7);
      exp_rsp[0] = (c % 2 == 1) && (c % 8 != 7);
      @(negedge clk);
      checks++;
      if ({mem_ce_o, mem_addr_o} !== exp_issue) begin
        errors++; $display("FAIL arb_issue c=%0d got %h want %h", c, {mem_ce_o, mem_addr_o},
                           exp_issue);
      end
      checks++;
      if ({fetch_valid_o, ld_ack_o} !== exp_rsp) begin
        errors++; $display("FAIL arb_strobe c=%0d got %b want %b", c,
                           {fetch_valid_o, ld_ack_o}, exp_rsp);
      end
      next_cycle();
    end
    fetch_req_i = 0; ld_req_i = 0;
  endtask

  task automatic test_reset_in_load();
    next_cycle();
    ld_req_i = 1; ld_we_i = 0; ld_addr_i = 32'h0000_0004;
    fetch_req_i = 1; fetch_addr_i = 32'h0000_0010;
    @(negedge clk);
    checks++;
    if ({mem_ce_o, mem_addr_o} !== {1'b1, 32'h4}) begin
      errors++; $display("FAIL rstld_issue got ce=%b addr=%h want 1 4", mem_ce_o, mem_addr_o);
    end
    next_cycle();
    rst = 1; ld_req_i = 0;
    @(negedge clk);
    checks++;
    if ({ld_ack_o, ld_rdata_o, mem_ce_o} !== 34'h0) begin
      errors++; $display("FAIL rstld_no_ack got ack=%b d=%h ce=%b want 0", ld_ack_o, ld_rdata_o,
                         mem_ce_o);
    end
    next_cycle();
    rst = 0;
    @(negedge clk);
    checks++;
    if ({ld_ack_o, mem_ce_o, mem_addr_o} !== {2'b01, 32'h10}) begin
      errors++; $display("FAIL rstld_fetch_issue got ack=%b ce=%b addr=%h want 0 1 10",
                         ld_ack_o, mem_ce_o, mem_addr_o);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({fetch_valid_o, ld_ack_o, fetch_rdata_o} !== {2'b10, 32'h3401_0020}) begin
      errors++; $display("FAIL rstld_fetch_rsp got v=%b ack=%b d=%h want 1 0 34010020",
                         fetch_valid_o, ld_ack_o, fetch_rdata_o);
    end
    next_cycle();
    fetch_req_i = 0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_ld_write_read();
    test_misalign();
    test_arbitration();
    test_reset_in_load();
    repeat (2) next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_mem_arbiter.md
INST_MEM_ARBITER -- requirements
Module: inst_mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset (`RstEnable).
REQ-002 The fetch port SHALL consist of: fetch_req_i  in  1  fetch request; fetch_addr_i  in  `InstAddrBus  fetch byte address; fetch_rdata_o  out  `InstBus  fetched instruction; fetch_valid_o  out  1  one-cycle response strobe; fetch_misalign_o  out  1  misaligned-address flag, valid with fetch_valid_o; stall_req_o  out  1  pipeline stall request.
REQ-003 The loader/debug port SHALL consist of: ld_req_i  in  1  request; ld_we_i  in  1  1=write, 0=read; ld_addr_i  in  `InstAddrBus  byte address; ld_wdata_i  in  `InstBus  write data; ld_ack_o  out  1  one-cycle completion strobe; ld_rdata_o  out  `InstBus  read data.
REQ-004 The memory port SHALL consist of: mem_ce_o  out  1  chip enable (`ChipEnable/`ChipDisable); mem_we_o  out  1  write enable; mem_addr_o  out  `InstAddrBus  byte address; mem_wdata_o  out  `InstBus  write data; mem_rdata_i  in  `InstBus  read data, valid exactly 1 cycle after a mem_ce_o cycle.
REQ-005 The parameter LD_MAX_STREAK SHALL default to 3 and SHALL give the maximum number of consecutive loader grants while a fetch is pending.

Function
REQ-006 The FSM SHALL have the states IDLE, FETCH_RSP and LOAD_RSP; each memory access SHALL take 2 cycles (issue in IDLE, response in *_RSP).
REQ-007 In IDLE with a request present, the block SHALL drive mem_ce_o=1 and the winner's address, we and wdata combinationally in that cycle, then move to the winner's *_RSP state.
REQ-008 Arbitration: the loader SHALL win when both requesters are active, unless ld_streak==LD_MAX_STREAK, in which case the fetch SHALL win.
REQ-009 ld_streak SHALL increment on each loader grant while fetch_req_i=1, SHALL saturate at LD_MAX_STREAK, and SHALL clear on any fetch grant or on any cycle with fetch_req_i=0.
REQ-010 In FETCH_RSP, the block SHALL drive fetch_rdata_o=mem_rdata_i and fetch_valid_o=1 for exactly one cycle, then return to IDLE.
REQ-011 In LOAD_RSP, the block SHALL drive ld_ack_o=1 for one cycle, with ld_rdata_o=mem_rdata_i for reads and `ZeroWord for writes, then return to IDLE.
REQ-012 A fetch with fetch_addr_i[1:0]!=0 SHALL NOT access memory (mem_ce_o=0); it SHALL still occupy FETCH_RSP and return fetch_valid_o=1, fetch_misalign_o=1 and fetch_rdata_o=`ZeroWord.
REQ-013 Loader addresses SHALL be forced word-aligned: mem_addr_o[1:0]=2'b00, with ld_addr_i[1:0] ignored.
REQ-014 Requesters SHALL hold req, addr, we and wdata stable until their strobe; the block SHALL sample them only in IDLE.
REQ-015 stall_req_o SHALL equal fetch_req_i & ~fetch_valid_o in every cycle.
REQ-016 Outside of the cases above, mem_ce_o SHALL be `ChipDisable, mem_we_o 0, and all data and address outputs `ZeroWord.
REQ-017 A request deasserted before grant SHALL be dropped silently; a request deasserted while its response is pending SHALL still receive its strobe.

Reset
REQ-018 While rst=1, the state SHALL be IDLE, ld_streak 0, and all outputs 0/`ZeroWord, with mem_ce_o=`ChipDisable.
REQ-019 A reset during FETCH_RSP or LOAD_RSP SHALL abort the access, and no strobe SHALL be issued for it afterwards.

Structure
REQ-020 State encodings and LD_MAX_STREAK's default SHALL live in the shared Defines.v; bus widths SHALL use the existing `InstAddrBus/`InstBus/`ZeroWord/`ChipEnable macros.
REQ-021 The priority/streak decision SHALL be a sub-module, inst_arb_prio (inputs: both requests and ld_streak; output: grant).
REQ-022 The memory SHALL be instantiated outside this block.

Verification
REQ-023 Fetch only, addr 0x0000_0010, mem word 0x3401_0020 -> mem_ce_o at cycle 0, fetch_valid_o and rdata 0x3401_0020 at cycle 1, stall_req_o 1 at cycle 0 and 0 at cycle 1.
REQ-024 Loader write 0xDEAD_BEEF to 0x0000_0007 -> mem_addr_o 0x0000_0004, mem_we_o 1, ld_ack_o 1 cycle later; a following loader read of 0x4 -> ld_rdata_o 0xDEAD_BEEF.
REQ-025 Both requesters held continuously -> grant order L,L,L,F,L,L,L,F; fetch_valid_o every 8th cycle.
REQ-026 Fetch addr 0x0000_0002 -> mem_ce_o stays 0, fetch_valid_o=1, fetch_misalign_o=1, rdata 0 at cycle 1.
REQ-027 rst asserted in LOAD_RSP -> no ld_ack_o; next cycle after rst drops, IDLE with all outputs 0; pending fetch is then granted normally.
